// File: rtl/count_shifter.sv
// -----------------------------------------------------------------------------
// count_shifter
//
// Sequential shifter for floating-point mantissa work. On a Load strobe it
// captures an operand, a shift count and a direction. It then shifts the
// operand one bit per clock until the count runs out. Right shifts are used
// for alignment and left shifts for normalisation.
//
// Optional build macro:
//   COUNT_SHIFTER_ARITH_RIGHT_EN
//     When defined, right shifts are arithmetic: the fill bit repeats the MSB.
//     An out-of-range right shift loads {WIDTH{Data[WIDTH-1]}}.
//     Left shifts always fill with zeros.
//     When undefined, every shift is logical and fills with zeros.
//
// Ports:
//   Clk          rising-edge clock
//   Clear_n      asynchronous active-low reset; clears all state immediately
//                and has priority over Load
//   Data         operand captured on Load
//   Count        number of single-bit shifts to perform
//   Load         synchronous capture strobe, active-high; highest synchronous
//                priority, and it aborts any shift in progress
//   Direction    0 = right, 1 = left; captured on Load, ignored otherwise
//   Result       shift register contents (registered)
//   shift_enable high while the remaining count is non-zero; decoded from a
//                register only, so there is no combinational path from inputs
// -----------------------------------------------------------------------------
module count_shifter #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Clear_n,
  input  logic [WIDTH-1:0] Data,
  input  logic [CNT_W-1:0] Count,
  input  logic             Load,
  input  logic             Direction,
  output logic [WIDTH-1:0] Result,
  output logic             shift_enable
);

  // A count of WIDTH or more would push every bit out. Such a load finishes
  // at once with the fully shifted value, and no cycles are spent shifting.
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] rem;
  logic             dir;

  logic             right_fill;
  logic [WIDTH-1:0] overflow_value;

`ifdef COUNT_SHIFTER_ARITH_RIGHT_EN
  assign right_fill     = shreg[WIDTH-1];
  assign overflow_value = Direction ? '0 : {WIDTH{Data[WIDTH-1]}};
`else
  assign right_fill     = 1'b0;
  assign overflow_value = '0;
`endif

  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      shreg <= '0;
      rem   <= '0;
      dir   <= 1'b0;
    end else if (Load) begin
      dir <= Direction;
      if (Count > MAX_CNT) begin
        shreg <= overflow_value;
        rem   <= '0;
      end else begin
        shreg <= Data;
        rem   <= Count;
      end
    end else if (rem != '0) begin
      if (dir) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
      end else begin
        shreg <= {right_fill, shreg[WIDTH-1:1]};
      end
      rem <= rem - CNT_W'(1);
    end
  end

  assign Result       = shreg;
  assign shift_enable = (rem != '0);

endmodule

// File: tb/tb_count_shifter.sv
// -----------------------------------------------------------------------------
// tb_count_shifter
//
// Directed testbench for count_shifter. Each scenario task drives its own
// stimulus and compares the outputs against hand-computed values. Outputs are
// sampled 1 ns after the rising edge. Inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_count_shifter;

  logic        Clk;
  logic        Clear_n;
  logic [23:0] Data;
  logic [7:0]  Count;
  logic        Load;
  logic        Direction;
  logic [23:0] Result;
  logic        shift_enable;

  int n_compared   = 0;
  int n_mismatched = 0;

  count_shifter #(.WIDTH(24), .CNT_W(8)) dut (
    .Clk          (Clk),
    .Clear_n      (Clear_n),
    .Data         (Data),
    .Count        (Count),
    .Load         (Load),
    .Direction    (Direction),
    .Result       (Result),
    .shift_enable (shift_enable)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // advance n rising edges and settle 1 ns past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // one-cycle Load pulse; returns 1 ns after the capturing edge with Load low
  task automatic do_load(input logic [23:0] d, input logic [7:0] c, input logic dr);
    @(negedge Clk);
    Data      = d;
    Count     = c;
    Direction = dr;
    Load      = 1'b1;
    tick(1);
    Load      = 1'b0;
  endtask

  task automatic test_reset;
    n_compared++;
    if (Result !== 24'h0 || shift_enable !== 1'b0) begin
      $display("FAIL reset_state: Result=%h se=%b, required Result=000000 se=0", Result, shift_enable);
      n_mismatched++;
    end
  endtask

  task automatic test_right;
    int highs;
    do_load(24'h0F0FFE, 8'd6, 1'b0);
    n_compared++;
    if (Result !== 24'h0F0FFE) begin
      $display("FAIL right_load: Result=%h, required 0F0FFE", Result);
      n_mismatched++;
    end
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      if (shift_enable === 1'b1) highs++;
      tick(1);
    end
    n_compared++;
    if (highs != 6) begin
      $display("FAIL right_enable_cycles: %0d cycles high, required 6", highs);
      n_mismatched++;
    end
    n_compared++;
    if (Result !== 24'h003C3F || shift_enable !== 1'b0) begin
      $display("FAIL right_result: Result=%h se=%b, required 003C3F se=0", Result, shift_enable);
      n_mismatched++;
    end
  endtask

  task automatic test_right_exact_latency;
    do_load(24'h0F0FFE, 8'd6, 1'b0);
    tick(5);
    n_compared++;
    if (Result !== 24'h00787F || shift_enable !== 1'b1) begin
      $display("FAIL right_edge_k5: Result=%h se=%b, required 00787F se=1", Result, shift_enable);
      n_mismatched++;
    end
    tick(1);
    n_compared++;
    if (Result !== 24'h003C3F || shift_enable !== 1'b0) begin
      $display("FAIL right_edge_k6: Result=%h se=%b, required 003C3F se=0", Result, shift_enable);
      n_mismatched++;
    end
    tick(3);
    n_compared++;
    if (Result !== 24'h003C3F) begin
      $display("FAIL right_hold: Result=%h, required 003C3F", Result);
      n_mismatched++;
    end
  endtask

  task automatic test_left_dir_ignored;
    do_load(24'hA15FC2, 8'd4, 1'b1);
    // flipping Direction mid-shift must not change the stored direction
    @(negedge Clk);
    Direction = 1'b0;
    tick(4);
    n_compared++;
    if (Result !== 24'h15FC20 || shift_enable !== 1'b0) begin
      $display("FAIL left_result: Result=%h se=%b, required 15FC20 se=0", Result, shift_enable);
      n_mismatched++;
    end
  endtask

  task automatic test_zero_count;
    int highs;
    do_load(24'hFF00FE, 8'd0, 1'b0);
    n_compared++;
    if (Result !== 24'hFF00FE) begin
      $display("FAIL zero_count_result: Result=%h, required FF00FE", Result);
      n_mismatched++;
    end
    highs = 0;
    for (int i = 0; i < 4; i++) begin
      if (shift_enable !== 1'b0) highs++;
      tick(1);
    end
    n_compared++;
    if (highs != 0 || Result !== 24'hFF00FE) begin
      $display("FAIL zero_count_hold: se high %0d cycles Result=%h, required 0 cycles FF00FE", highs, Result);
      n_mismatched++;
    end
  endtask

  task automatic test_out_of_range;
    logic [23:0] exp_r;
    do_load(24'h5ABCDE, 8'd30, 1'b0);
    n_compared++;
    if (Result !== 24'h000000 || shift_enable !== 1'b0) begin
      $display("FAIL oor_30: Result=%h se=%b, required 000000 se=0", Result, shift_enable);
      n_mismatched++;
    end
    // Count=24 is the first out-of-range value; left always zero-fills
    do_load(24'hFFFFFF, 8'd24, 1'b1);
    n_compared++;
    if (Result !== 24'h000000 || shift_enable !== 1'b0) begin
      $display("FAIL oor_24_left: Result=%h se=%b, required 000000 se=0", Result, shift_enable);
      n_mismatched++;
    end
`ifdef COUNT_SHIFTER_ARITH_RIGHT_EN
    exp_r = 24'hFFFFFF;
`else
    exp_r = 24'h000000;
`endif
    do_load(24'h800000, 8'd24, 1'b0);
    n_compared++;
    if (Result !== exp_r || shift_enable !== 1'b0) begin
      $display("FAIL oor_24_right: Result=%h se=%b, required %h se=0", Result, shift_enable, exp_r);
      n_mismatched++;
    end
    // Count=23 is the largest in-range value
`ifdef COUNT_SHIFTER_ARITH_RIGHT_EN
    exp_r = 24'hFFFFFF;
`else
    exp_r = 24'h000001;
`endif
    do_load(24'h800000, 8'd23, 1'b0);
    tick(23);
    n_compared++;
    if (Result !== exp_r || shift_enable !== 1'b0) begin
      $display("FAIL count_23: Result=%h se=%b, required %h se=0", Result, shift_enable, exp_r);
      n_mismatched++;
    end
  endtask

  task automatic test_reset_priority;
    do_load(24'h123456, 8'd0, 1'b0);
    // assert reset together with Load, away from a clock edge
    @(negedge Clk);
    Data      = 24'h7FFFFF;
    Count     = 8'd5;
    Direction = 1'b1;
    Load      = 1'b1;
    Clear_n   = 1'b0;
    #1;
    n_compared++;
    if (Result !== 24'h0 || shift_enable !== 1'b0) begin
      $display("FAIL reset_async: Result=%h se=%b, required 000000 se=0", Result, shift_enable);
      n_mismatched++;
    end
    tick(1);
    n_compared++;
    if (Result !== 24'h0 || shift_enable !== 1'b0) begin
      $display("FAIL reset_over_load: Result=%h se=%b, required 000000 se=0", Result, shift_enable);
      n_mismatched++;
    end
    @(negedge Clk);
    Load    = 1'b0;
    Clear_n = 1'b1;
    tick(3);
    n_compared++;
    if (Result !== 24'h0 || shift_enable !== 1'b0) begin
      $display("FAIL reset_release_idle: Result=%h se=%b, required 000000 se=0", Result, shift_enable);
      n_mismatched++;
    end
  endtask

  task automatic test_reset_mid_shift;
    do_load(24'h0F0FFE, 8'd6, 1'b0);
    tick(2);
    #2;
    Clear_n = 1'b0;
    #1;
    n_compared++;
    if (Result !== 24'h0 || shift_enable !== 1'b0) begin
      $display("FAIL reset_mid_shift: Result=%h se=%b, required 000000 se=0", Result, shift_enable);
      n_mismatched++;
    end
    @(negedge Clk);
    Clear_n = 1'b1;
    tick(6);
    n_compared++;
    if (Result !== 24'h0 || shift_enable !== 1'b0) begin
      $display("FAIL reset_mid_after: Result=%h se=%b, required 000000 se=0", Result, shift_enable);
      n_mismatched++;
    end
  endtask

  task automatic test_back_to_back;
    logic [23:0] exp_r;
    do_load(24'h0F0FFE, 8'd6, 1'b0);
    tick(1);
    do_load(24'hA15FC2, 8'd4, 1'b0);
    n_compared++;
    if (Result !== 24'hA15FC2 || shift_enable !== 1'b1) begin
      $display("FAIL reload_capture: Result=%h se=%b, required A15FC2 se=1", Result, shift_enable);
      n_mismatched++;
    end
    tick(4);
`ifdef COUNT_SHIFTER_ARITH_RIGHT_EN
    exp_r = 24'hFA15FC;
`else
    exp_r = 24'h0A15FC;
`endif
    n_compared++;
    if (Result !== exp_r || shift_enable !== 1'b0) begin
      $display("FAIL reload_result: Result=%h se=%b, required %h se=0", Result, shift_enable, exp_r);
      n_mismatched++;
    end
  endtask

  task automatic test_load_held;
    @(negedge Clk);
    Data      = 24'h000001;
    Count     = 8'd3;
    Direction = 1'b1;
    Load      = 1'b1;
    tick(3);
    n_compared++;
    if (Result !== 24'h000001 || shift_enable !== 1'b1) begin
      $display("FAIL load_held: Result=%h se=%b, required 000001 se=1", Result, shift_enable);
      n_mismatched++;
    end
    Load = 1'b0;
    tick(3);
    n_compared++;
    if (Result !== 24'h000008 || shift_enable !== 1'b0) begin
      $display("FAIL load_held_release: Result=%h se=%b, required 000008 se=0", Result, shift_enable);
      n_mismatched++;
    end
  endtask

  initial begin
    Clear_n   = 1'b0;
    Load      = 1'b0;
    Data      = '0;
    Count     = '0;
    Direction = 1'b0;
    tick(2);
    test_reset;
    @(negedge Clk);
    Clear_n = 1'b1;
    tick(1);
    test_reset;
    test_right;
    test_right_exact_latency;
    test_left_dir_ignored;
    test_zero_count;
    test_out_of_range;
    test_reset_priority;
    test_reset_mid_shift;
    test_back_to_back;
    test_load_held;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
